// File: rtl/train_dispatch_scheduler.sv
// rtl/train_dispatch_scheduler.sv - round-robin pickup-train dispatcher with per-station in-flight tracking
// Optional offer watchdog enabled by defining TRAIN_SCHED_WATCHDOG_EN.
module train_dispatch_scheduler #(
  parameter int NST      = 4,
  parameter int LW       = 4,
  parameter int HOLD_CYC = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [NST*LW-1:0]      l_req_i,
  input  logic [NST-1:0]         arrive_i,
  output logic                   dispatch_valid_o,
  input  logic                   dispatch_ready_i,
  output logic [$clog2(NST)-1:0] dispatch_dest_o,
  output logic [NST*LW-1:0]      inflight_o,
`ifdef TRAIN_SCHED_WATCHDOG_EN
  output logic                   timeout_err_o,
  input  logic                   err_clr_i,
`endif
  output logic                   busy_o
);
  localparam int DW = $clog2(NST);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [LW-1:0] LMAX = '1;

  typedef enum logic [1:0] {IDLE, ARB, OFFER, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dest_q, dest_d, rr_q, rr_d, win;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NST*LW-1:0] infl_q, infl_d;
  logic [NST-1:0]    elig;
  logic [LW-1:0]     cur, nxt;
  logic              found, hs, wd_fire, inc, dec;
  int                idx;

  assign hs = (state_q == OFFER) && dispatch_ready_i;

`ifdef TRAIN_SCHED_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  assign wd_fire = (state_q == OFFER) && !dispatch_ready_i && (wd_q == TW'(TIMEOUT - 1));
  assign wd_d    = (state_q == OFFER) ? wd_q + 1'b1 : '0;
  // A timeout in the same cycle as a clear leaves the flag set.
  assign err_d   = wd_fire | (err_q & ~err_clr_i);
  assign timeout_err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Winner is the first eligible station at or after rr_q; scanning backwards lets k=0 win last.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NST; i++) begin
      elig[i] = l_req_i[i*LW +: LW] > infl_q[i*LW +: LW];
    end
    for (int k = NST - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NST;
      if (elig[idx]) begin
        found = 1'b1;
        win   = DW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (enable_i) state_d = ARB;
      ARB: begin
        if (found) begin
          dest_d  = win;
          state_d = OFFER;
        end else begin
          state_d = IDLE;
        end
      end
      OFFER: begin
        if (hs) begin
          rr_d    = (dest_q == DW'(NST - 1)) ? '0 : dest_q + 1'b1;
          state_d = HOLD;
          hold_d  = '0;
        end else if (wd_fire) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (hold_q == HW'(HOLD_CYC - 1)) state_d = IDLE;
        else hold_d = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Net change per station: a handshake and an arrival in the same cycle cancel.
  always_comb begin
    infl_d = infl_q;
    cur    = '0;
    nxt    = '0;
    inc    = 1'b0;
    dec    = 1'b0;
    for (int i = 0; i < NST; i++) begin
      cur = infl_q[i*LW +: LW];
      nxt = cur;
      inc = hs && (dest_q == DW'(i));
      dec = arrive_i[i];
      if (inc && !dec) begin
        if (cur != LMAX) nxt = cur + 1'b1;
      end else if (dec && !inc) begin
        if (cur != '0) nxt = cur - 1'b1;
      end
      infl_d[i*LW +: LW] = nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dest_q  <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      infl_q  <= infl_d;
    end
  end

  assign dispatch_valid_o = (state_q == OFFER);
  assign dispatch_dest_o  = dest_q;
  assign inflight_o       = infl_q;
  assign busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_train_dispatch_scheduler.sv
// tb/tb_train_dispatch_scheduler.sv - scoreboard bench for train_dispatch_scheduler
module tb_train_dispatch_scheduler;
  localparam int NST  = 4;
  localparam int LW   = 4;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          ready = 1'b0;
  logic [15:0]   l_req = '0;
  logic [3:0]    arrive = '0;
  logic          valid, busy;
  logic [1:0]    dest;
  logic [15:0]   inflight;
`ifdef TRAIN_SCHED_WATCHDOG_EN
  logic          err_clr = 1'b0;
  logic          timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int cyc     = 0;
  int last_hs = -1;
  bit gap_chk = 1'b0;

  train_dispatch_scheduler #(.NST(NST), .LW(LW), .HOLD_CYC(HOLD), .TIMEOUT(64)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .l_req_i          (l_req),
    .arrive_i         (arrive),
    .dispatch_valid_o (valid),
    .dispatch_ready_i (ready),
    .dispatch_dest_o  (dest),
    .inflight_o       (inflight),
`ifdef TRAIN_SCHED_WATCHDOG_EN
    .timeout_err_o    (timeout_err),
    .err_clr_i        (err_clr),
`endif
    .busy_o           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int infl(input int i);
    return int'(inflight[i*LW +: LW]);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!valid && n < budget) begin
      tick(1);
      n++;
    end
    check("valid_wait", int'(valid), 1);
  endtask

  // Scoreboard: every handshake must match the next expected destination.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_dispatch", int'(dest), -1);
      end else begin
        check("sb_dest", int'(dest), exp_q.pop_front());
      end
      if (gap_chk && last_hs >= 0) check("rr_gap", cyc - last_hs, HOLD + 3);
      last_hs = cyc;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    check("rst_valid", int'(valid), 0);
    check("rst_dest", int'(dest), 0);
    check("rst_inflight", int'(inflight), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(2);

    // Round-robin over all stations with L=1
    l_req = 16'h1111;
    ready = 1'b1;
    gap_chk = 1'b1;
    for (int i = 0; i < NST; i++) exp_q.push_back(i);
    enable = 1'b1;
    tick(1);
    check("lat_arb_valid", int'(valid), 0);
    tick(1);
    check("lat_offer_valid", int'(valid), 1);
    tick(80);
    gap_chk = 1'b0;
    for (int i = 0; i < NST; i++) check("rr_inflight", infl(i), 1);
    check("rr_pending", exp_q.size(), 0);
    enable = 1'b0;
    tick(4);

    // Reset while offering to station 2
    l_req = 16'h1211;
    ready = 1'b0;
    enable = 1'b1;
    wait_valid(10);
    check("pre_rst_dest", int'(dest), 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_inflight", int'(inflight), 0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    check("post_rst_busy", int'(busy), 0);

    // Limit then arrival
    l_req = 16'h0003;
    ready = 1'b1;
    repeat (3) exp_q.push_back(0);
    enable = 1'b1;
    tick(60);
    check("lim_inflight0", infl(0), 3);
    check("lim_pending", exp_q.size(), 0);
    exp_q.push_back(0);
    arrive = 4'b0001;
    tick(1);
    arrive = 4'b0000;
    tick(30);
    check("arr_inflight0", infl(0), 3);
    check("arr_pending", exp_q.size(), 0);

    // Boundary: arrival at zero, then handshake with same-cycle arrival
    enable = 1'b0;
    ready = 1'b0;
    tick(3);
    arrive = 4'b0010;
    tick(1);
    arrive = 4'b0000;
    tick(1);
    check("arr_at_zero", infl(1), 0);
    l_req = 16'h0013;
    exp_q.push_back(1);
    enable = 1'b1;
    wait_valid(10);
    check("bnd_dest", int'(dest), 1);
    enable = 1'b0;
    ready = 1'b1;
    arrive = 4'b0010;
    tick(1);
    ready = 1'b0;
    arrive = 4'b0000;
    check("hs_arrive_net0", infl(1), 0);
    tick(HOLD + 3);

    // Backpressure with enable and l_req changing under the offer
    exp_q.push_back(1);
    enable = 1'b1;
    wait_valid(10);
    check("bp_dest0", int'(dest), 1);
    enable = 1'b0;
    l_req = '0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("bp_valid_hold", int'(valid), 1);
      check("bp_dest_hold", int'(dest), 1);
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("bp_inflight1", infl(1), 1);
    check("bp_valid_drop", int'(valid), 0);
    tick(HOLD + 4);
    check("bp_idle", int'(busy), 0);
    check("bp_pending", exp_q.size(), 0);

`ifdef TRAIN_SCHED_WATCHDOG_EN
    begin
      int n = 0;
      l_req = 16'h0100;
      enable = 1'b1;
      wait_valid(10);
      enable = 1'b0;
      while (valid && n < 200) begin
        n++;
        tick(1);
      end
      check("wd_valid_cycles", n, 64);
      check("wd_err_set", int'(timeout_err), 1);
      check("wd_inflight2", infl(2), 0);
      tick(HOLD + 3);
      check("wd_err_sticky", int'(timeout_err), 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("wd_err_clr", int'(timeout_err), 0);
    end
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
